// File: rtl/if_stage_buffered_pkg.sv
// Shared constants and bus layouts for the buffered instruction-fetch stage.
package if_stage_buffered_pkg;
   localparam logic [31:0] RESET_PC_DEF   = 32'h1c00_0000;
   localparam int          BR_BUS_W       = 33;
   localparam int          FS_TO_DS_BUS_W = 64;
   localparam logic [1:0]  SRAM_SIZE_WORD = 2'b10;
   localparam logic        SRAM_WR_READ   = 1'b0;

   typedef struct packed {
      logic        br_taken;
      logic [31:0] br_target;
   } br_bus_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fs_to_ds_t;
endpackage

// File: rtl/if_stage_buffered_if.sv
// Inst-SRAM split-transaction port plus the IF<->ID handshake of the fetch stage.
interface if_stage_buffered_if;
   import if_stage_buffered_pkg::*;

   logic                      inst_sram_req;
   logic                      inst_sram_wr;
   logic [1:0]                inst_sram_size;
   logic [3:0]                inst_sram_wstrb;
   logic [31:0]               inst_sram_addr;
   logic [31:0]               inst_sram_wdata;
   logic                      inst_sram_addr_ok;
   logic                      inst_sram_data_ok;
   logic [31:0]               inst_sram_rdata;
   logic                      id_allowin;
   logic [BR_BUS_W-1:0]       id_to_if_bus;
   logic                      if_to_id_valid;
   logic [FS_TO_DS_BUS_W-1:0] if_to_id_bus;

   modport master (
      output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata, if_to_id_valid, if_to_id_bus,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
             id_allowin, id_to_if_bus
   );

   modport slave (
      input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata, if_to_id_valid, if_to_id_bus,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
             id_allowin, id_to_if_bus
   );
endinterface

// File: rtl/if_stage_buffered_sync_fifo.sv
// Synchronous FIFO with flush; used for the instruction queue and the in-flight PC queue.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a push into a full queue is legal only when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/if_stage_buffered.sv
// Buffered IF stage: credit-limited split-transaction fetch, instruction queue,
// and branch redirect with cancellation of stale in-flight responses.
module if_stage_buffered
   import if_stage_buffered_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
   parameter int          IBUF_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input logic                 clk,
   input logic                 reset,
   if_stage_buffered_if.master bus
);
   localparam int CW = $clog2(IBUF_DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

   br_bus_t     br;
   fs_to_ds_t   ibuf_head;
   logic [31:0] fetch_pc;
   logic [31:0] redirect_pc;
   logic        redirect_pending;
   logic [CW-1:0] cancel_cnt;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_nxt;
   logic [OW-1:0] pcq_count;
   logic [CW-1:0] ibuf_count;
   logic        pcq_empty, pcq_full, ibuf_empty, ibuf_full;
   logic [31:0] resp_pc;
   logic        req, hs, resp, drop, ibuf_push, ibuf_pop;

   assign br          = br_bus_t'(bus.id_to_if_bus);
   assign outstanding = CW'(pcq_count);

   // credit rule: every request in flight owns a queue slot, so the ibuf cannot overflow
   assign req  = ~reset & ~pcq_full &
                 (({1'b0, outstanding} + {1'b0, ibuf_count}) < (CW + 1)'(IBUF_DEPTH));
   assign hs   = req & bus.inst_sram_addr_ok;
   assign resp = bus.inst_sram_data_ok;
   assign drop = resp & (cancel_cnt != '0);

   assign ibuf_push = resp & ~drop & ~br.br_taken;
   assign ibuf_pop  = ~ibuf_empty & bus.id_allowin;
   assign outstanding_nxt = outstanding + CW'(hs) - CW'(resp);

   sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pcq (
      .clk   (clk),
      .reset (reset),
      .flush (1'b0),
      .push  (hs),
      .din   (fetch_pc),
      .pop   (resp),
      .dout  (resp_pc),
      .count (pcq_count),
      .empty (pcq_empty),
      .full  (pcq_full)
   );

   sync_fifo #(.WIDTH(FS_TO_DS_BUS_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
      .clk   (clk),
      .reset (reset),
      .flush (br.br_taken),
      .push  (ibuf_push),
      .din   ({bus.inst_sram_rdata, resp_pc}),
      .pop   (ibuf_pop),
      .dout  (ibuf_head),
      .count (ibuf_count),
      .empty (ibuf_empty),
      .full  (ibuf_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc         <= RESET_PC;
         redirect_pc      <= '0;
         redirect_pending <= 1'b0;
         cancel_cnt       <= '0;
      end else if (br.br_taken) begin
         cancel_cnt <= outstanding_nxt;
         // a request already on the bus must not be withdrawn; park the target until it completes
         if (req && !bus.inst_sram_addr_ok) begin
            redirect_pending <= 1'b1;
            redirect_pc      <= br.br_target;
         end else begin
            redirect_pending <= 1'b0;
            fetch_pc         <= br.br_target;
         end
      end else begin
         cancel_cnt <= cancel_cnt - CW'(drop) + CW'(hs & redirect_pending);
         if (hs) begin
            fetch_pc         <= redirect_pending ? redirect_pc : fetch_pc + 32'd4;
            redirect_pending <= 1'b0;
         end
      end
   end

   assign bus.inst_sram_req   = req;
   assign bus.inst_sram_addr  = fetch_pc;
   assign bus.inst_sram_wr    = SRAM_WR_READ;
   assign bus.inst_sram_size  = SRAM_SIZE_WORD;
   assign bus.inst_sram_wstrb = 4'b0000;
   assign bus.inst_sram_wdata = 32'h0;
   assign bus.if_to_id_valid  = ~ibuf_empty;
   assign bus.if_to_id_bus    = ibuf_empty ? '0 : ibuf_head;

   a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(ibuf_full && ibuf_push && !ibuf_pop && !br.br_taken));
   a_resp_has_req: assert property (@(posedge clk) disable iff (reset)
      !(resp && pcq_empty));
endmodule

// File: tb/tb_if_stage_buffered.sv
// Bench for if_stage_buffered: SRAM responder model, PC-stream scoreboard, directed and random phases.
module tb_if_stage_buffered;
   localparam logic [31:0] RST_PC = 32'h1c00_0000;
   localparam int          MO     = 2;

   typedef struct {
      int          rdy;
      logic [31:0] addr;
   } pend_t;

   logic clk = 1'b0;
   logic reset;
   logic allowin;
   logic br_taken;
   logic [31:0] br_target;

   int total = 0;
   int bad = 0;
   int n_pop = 0;
   int cyc = 0;
   int max_pend = 0;
   int unstable = 0;
   int aok_mode = 0;
   bit dok_rand = 0;
   int resp_delay = 1;

   logic [63:0] exp_q[$];
   logic [31:0] exp_pc;
   pend_t       pend[$];

   if_stage_buffered_if sif();

   if_stage_buffered #(
      .RESET_PC        (RST_PC),
      .IBUF_DEPTH      (4),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   assign sif.id_allowin   = allowin;
   assign sif.id_to_if_bus = {br_taken, br_target};

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5a5a_a5a5;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic top_up();
      while (exp_q.size() < 32) begin
         exp_q.push_back({inst_of(exp_pc), exp_pc});
         exp_pc += 32'd4;
      end
   endtask

   task automatic restart_model(input logic [31:0] pc);
      exp_q.delete();
      exp_pc = pc;
      top_up();
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      top_up();
   endtask

   task automatic redirect(input logic [31:0] tgt);
      br_taken  = 1'b1;
      br_target = tgt;
      restart_model(tgt);
   endtask

   task automatic wait_valid(input string name, input int bound);
      int n = 0;
      while (!sif.if_to_id_valid && n < bound) begin
         step();
         n++;
      end
      chk(name, 64'(sif.if_to_id_valid), 64'd1);
   endtask

   // SRAM responder: in-order responses resp_delay cycles after the handshake
   initial begin
      bit    held_prev = 0;
      logic [31:0] held_addr = '0;
      sif.inst_sram_addr_ok = 1'b0;
      sif.inst_sram_data_ok = 1'b0;
      sif.inst_sram_rdata   = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend.delete();
            held_prev = 0;
         end else begin
            if (held_prev && (!sif.inst_sram_req || sif.inst_sram_addr != held_addr))
               unstable++;
            held_prev = sif.inst_sram_req && !sif.inst_sram_addr_ok;
            held_addr = sif.inst_sram_addr;
            if (sif.inst_sram_data_ok) void'(pend.pop_front());
            if (sif.inst_sram_req && sif.inst_sram_addr_ok)
               pend.push_back('{rdy: cyc + resp_delay, addr: sif.inst_sram_addr});
            if (pend.size() > max_pend) max_pend = pend.size();
         end
         @(posedge clk);
         #1;
         case (aok_mode)
            0:       sif.inst_sram_addr_ok = 1'b1;
            1:       sif.inst_sram_addr_ok = ($urandom_range(3) != 0);
            default: sif.inst_sram_addr_ok = 1'b0;
         endcase
         if (pend.size() != 0 && pend[0].rdy <= cyc && (!dok_rand || $urandom_range(9) < 7)) begin
            sif.inst_sram_data_ok = 1'b1;
            sif.inst_sram_rdata   = inst_of(pend[0].addr);
         end else begin
            sif.inst_sram_data_ok = 1'b0;
            sif.inst_sram_rdata   = $urandom;
         end
      end
   end

   // monitor: every instruction ID accepts (outside a redirect cycle) is checked against the model
   initial forever begin
      @(negedge clk);
      if (!reset && sif.if_to_id_valid && allowin && !br_taken) begin
         if (exp_q.size() == 0) begin
            chk("id_stream_underflow", sif.if_to_id_bus, 64'hx);
         end else begin
            chk("id_stream", sif.if_to_id_bus, exp_q.pop_front());
         end
         n_pop++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int p0;
      int n;
      logic [31:0] held_a;

      reset     = 1'b1;
      allowin   = 1'b1;
      br_taken  = 1'b0;
      br_target = '0;
      exp_pc    = RST_PC;
      repeat (3) step();
      chk("rst_req",   64'(sif.inst_sram_req), 64'd0);
      chk("rst_valid", 64'(sif.if_to_id_valid), 64'd0);
      chk("rst_bus",   sif.if_to_id_bus, 64'd0);
      chk("rst_addr",  64'(sif.inst_sram_addr), 64'(RST_PC));

      // 1: free-running fetch
      restart_model(RST_PC);
      reset = 1'b0;
      #1;
      chk("t1_req0",   64'(sif.inst_sram_req), 64'd1);
      chk("t1_addr0",  64'(sif.inst_sram_addr), 64'h1c00_0000);
      chk("t1_size",   64'(sif.inst_sram_size), 64'd2);
      chk("t1_valid0", 64'(sif.if_to_id_valid), 64'd0);
      step();
      chk("t1_addr1",  64'(sif.inst_sram_addr), 64'h1c00_0004);
      chk("t1_valid1", 64'(sif.if_to_id_valid), 64'd0);
      step();
      chk("t1_valid2", 64'(sif.if_to_id_valid), 64'd1);
      chk("t1_head",   sif.if_to_id_bus, {inst_of(RST_PC), RST_PC});
      p0 = n_pop;
      repeat (10) step();
      chk("t1_rate", 64'(n_pop - p0), 64'd10);

      // 2: ID stall fills the queue, fetch stops on credits
      allowin = 1'b0;
      repeat (20) step();
      chk("t2_req",      64'(sif.inst_sram_req), 64'd0);
      chk("t2_valid",    64'(sif.if_to_id_valid), 64'd1);
      chk("t2_inflight", 64'(pend.size()), 64'd0);
      aok_mode = 2;
      allowin  = 1'b1;
      p0 = n_pop;
      repeat (6) step();
      chk("t2_buffered", 64'(n_pop - p0), 64'd4);
      chk("t2_empty",    64'(sif.if_to_id_valid), 64'd0);
      aok_mode = 0;
      repeat (6) step();

      // 3: redirect with two requests in flight
      resp_delay = 3;
      repeat (8) step();
      n = 0;
      while (pend.size() != 2 && n < 10) begin
         step();
         n++;
      end
      chk("t3_two_inflight", 64'(pend.size()), 64'd2);
      redirect(32'h1c00_0100);
      step();
      br_taken = 1'b0;
      wait_valid("t3_wait", 30);
      chk("t3_pc", 64'(sif.if_to_id_bus[31:0]), 64'h1c00_0100);
      resp_delay = 1;
      repeat (8) step();

      // 4: redirect while a request is held without addr_ok
      aok_mode = 2;
      step();
      step();
      chk("t4_req_held", 64'(sif.inst_sram_req), 64'd1);
      held_a = sif.inst_sram_addr;
      redirect(32'h1c00_0200);
      step();
      br_taken = 1'b0;
      chk("t4_addr_hold1", 64'(sif.inst_sram_addr), 64'(held_a));
      chk("t4_req_hold1",  64'(sif.inst_sram_req), 64'd1);
      step();
      chk("t4_addr_hold2", 64'(sif.inst_sram_addr), 64'(held_a));
      aok_mode = 0;
      step();
      chk("t4_addr_hold3", 64'(sif.inst_sram_addr), 64'(held_a));
      step();
      chk("t4_next_addr", 64'(sif.inst_sram_addr), 64'h1c00_0200);
      wait_valid("t4_wait", 30);
      chk("t4_pc", 64'(sif.if_to_id_bus[31:0]), 64'h1c00_0200);
      repeat (6) step();

      // 5: redirect coinciding with data_ok and an ID pop
      n = 0;
      while (!(sif.inst_sram_data_ok && sif.if_to_id_valid) && n < 10) begin
         step();
         n++;
      end
      chk("t5_dok", 64'(sif.inst_sram_data_ok), 64'd1);
      chk("t5_pre_valid", 64'(sif.if_to_id_valid), 64'd1);
      redirect(32'h1c00_0300);
      step();
      br_taken = 1'b0;
      chk("t5_empty",  64'(sif.if_to_id_valid), 64'd0);
      chk("t5_bus0",   sif.if_to_id_bus, 64'd0);
      chk("t5_cancel", 64'(dut.cancel_cnt), 64'(pend.size()));
      wait_valid("t5_wait", 30);
      chk("t5_pc", 64'(sif.if_to_id_bus[31:0]), 64'h1c00_0300);

      // 6: random stalls and branches against the PC model
      aok_mode = 1;
      dok_rand = 1;
      for (int d = 1; d <= 3; d++) begin
         resp_delay = d;
         repeat (150) begin
            step();
            allowin = ($urandom_range(3) != 0);
            if (!br_taken && $urandom_range(15) == 0)
               redirect({16'h1c01, 14'($urandom), 2'b00});
            else
               br_taken = 1'b0;
         end
      end
      step();
      br_taken   = 1'b0;
      allowin    = 1'b1;
      aok_mode   = 0;
      dok_rand   = 0;
      resp_delay = 1;
      repeat (20) step();
      chk("t6_valid", 64'(sif.if_to_id_valid), 64'd1);
      p0 = n_pop;
      repeat (10) step();
      chk("t6_stream", 64'(n_pop - p0), 64'd10);

      // reset in the middle of traffic
      reset = 1'b1;
      step();
      chk("mrst_req",   64'(sif.inst_sram_req), 64'd0);
      chk("mrst_valid", 64'(sif.if_to_id_valid), 64'd0);
      chk("mrst_bus",   sif.if_to_id_bus, 64'd0);
      step();
      chk("mrst_addr",  64'(sif.inst_sram_addr), 64'(RST_PC));
      restart_model(RST_PC);
      reset = 1'b0;
      p0 = n_pop;
      repeat (15) step();
      chk("mrst_stream", 64'(n_pop - p0), 64'd13);

      chk("max_outstanding_ok", 64'(max_pend <= MO), 64'd1);
      chk("req_stable", 64'(unstable), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
